// File: rtl/cpu6_dmem_resp_pkg.sv
// cpu6_dmem_resp_pkg
// Shared definitions for the data-side memory responder: data width, RAM
// depth, the MMIO page selector, the MMIO register offsets and the read FSM
// state encoding.
package cpu6_dmem_resp_pkg;

    localparam int          CPU6_XLEN    = 32;
    localparam int          CPU6_DMEM_AW = 10;
    localparam logic [15:0] CPU6_MMIO_HI = 16'hFFFF;

    // Offsets inside the MMIO page (addr[15:0]).
    localparam logic [15:0] CPU6_MMIO_CONSOLE = 16'h0000;
    localparam logic [15:0] CPU6_MMIO_TIMER   = 16'h0004;
    localparam logic [15:0] CPU6_MMIO_STATUS  = 16'h0008;

    // Read FSM: IDLE accepts requests, RESP presents load data for one cycle.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } cpu6_rd_state_e;

endpackage

// File: rtl/cpu6_dmem_ram.sv
// cpu6_dmem_ram
// Word-wide data RAM, 2**AW words, synchronous write and synchronous read.
// Contents are not reset.
// Ports:
//   clk      clock
//   addr_i   word address (shared by read and write)
//   we_i     write enable, writes wdata_i at the rising edge
//   re_i     read enable, rdata_o holds mem[addr_i] from the next cycle on
//   wdata_i  write data
//   rdata_o  registered read data
module cpu6_dmem_ram
    import cpu6_dmem_resp_pkg::*;
#(
    parameter int AW = CPU6_DMEM_AW
) (
    input  logic                 clk,
    input  logic [AW-1:0]        addr_i,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [CPU6_XLEN-1:0] wdata_i,
    output logic [CPU6_XLEN-1:0] rdata_o
);

    logic [CPU6_XLEN-1:0] mem_q [0:(1<<AW)-1];
    logic [CPU6_XLEN-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu6_dmem_resp.sv
// cpu6_dmem_resp
// Data-side memory responder for the core's MEM stage. Serves word loads and
// stores from an internal RAM and a small MMIO page (console transmit holding
// register, free-running timer, sticky error status), and stalls the core
// while a load is in flight or the console holding register cannot take a
// new byte.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   dataaddrM     byte address from MEM stage
//   writedataM    store data
//   memwriteM     store request
//   memreadM      load request
//   readdataM     load data, valid in the RESP cycle, 0 otherwise
//   stallM        hold the MEM stage this cycle
//   errM          sticky misaligned/illegal-access flag
//   tx_valid      console byte available
//   tx_data       console byte
//   tx_ready      console sink ready
//   dbg_state_o   read FSM state (0 = IDLE, 1 = RESP)
//
// Console handshake: a byte transfers on every rising edge where
// tx_valid & tx_ready; tx_valid never drops and tx_data never changes while
// tx_valid & !tx_ready, and a new byte may be loaded in the same cycle the
// old one transfers.
module cpu6_dmem_resp
    import cpu6_dmem_resp_pkg::*;
#(
    parameter int          DMEM_AW = CPU6_DMEM_AW,
    parameter logic [15:0] MMIO_HI = CPU6_MMIO_HI
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CPU6_XLEN-1:0] dataaddrM,
    input  logic [CPU6_XLEN-1:0] writedataM,
    input  logic                 memwriteM,
    input  logic                 memreadM,
    output logic [CPU6_XLEN-1:0] readdataM,
    output logic                 stallM,
    output logic                 errM,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 dbg_state_o
);

    cpu6_rd_state_e       state_q, state_d;
    logic                 rd_ram_q, rd_ram_d;
    logic [CPU6_XLEN-1:0] rd_mmio_q, rd_mmio_d;
    logic [CPU6_XLEN-1:0] timer_q, timer_d;
    logic                 err_q, err_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [7:0]           tx_data_q, tx_data_d;

    logic                 is_idle;
    logic                 is_mmio;
    logic                 misal;
    logic [15:0]          off;
    logic                 off_bad;
    logic                 any_req;
    logic                 rd_launch;
    logic                 wr_ok;
    logic                 ram_we;
    logic                 ram_re;
    logic                 con_wr;
    logic                 con_block;
    logic                 con_load;
    logic                 tim_wr;
    logic                 sts_clr;
    logic                 new_err;
    logic [CPU6_XLEN-1:0] mmio_val;
    logic [CPU6_XLEN-1:0] ram_rdata;

    // ---------------- decode ----------------
    // Requests seen in RESP belong to the load already being answered.
    assign is_idle = (state_q == ST_IDLE);
    assign is_mmio = (dataaddrM[31:16] == MMIO_HI);
    assign misal   = |dataaddrM[1:0];
    assign off     = dataaddrM[15:0];
    assign off_bad = is_mmio && (off != CPU6_MMIO_CONSOLE) &&
                     (off != CPU6_MMIO_TIMER) && (off != CPU6_MMIO_STATUS);
    assign any_req = memreadM | memwriteM;

    // A combined read+write is treated as a store; the load half is dropped.
    assign rd_launch = is_idle & memreadM & ~memwriteM;
    assign wr_ok     = is_idle & memwriteM & ~misal;

    assign ram_we    = wr_ok & ~is_mmio;
    assign ram_re    = rd_launch & ~is_mmio & ~misal;
    assign con_wr    = wr_ok & is_mmio & (off == CPU6_MMIO_CONSOLE);
    assign con_block = con_wr & tx_valid_q & ~tx_ready;
    assign con_load  = con_wr & ~con_block;
    assign tim_wr    = wr_ok & is_mmio & (off == CPU6_MMIO_TIMER);
    assign sts_clr   = wr_ok & is_mmio & (off == CPU6_MMIO_STATUS) & writedataM[0];
    assign new_err   = is_idle & ((memreadM & memwriteM) |
                                  (any_req & (misal | off_bad)));

    // Stall is combinational so the core sees it in the request cycle; it is
    // forced low while reset is asserted.
    assign stallM = ~reset & (rd_launch | con_block);

    // ---------------- MMIO read mux ----------------
    always_comb begin
        mmio_val = '0;
        case (off)
            CPU6_MMIO_CONSOLE: mmio_val = {{(CPU6_XLEN-1){1'b0}}, tx_valid_q};
            CPU6_MMIO_TIMER:   mmio_val = timer_q;
            CPU6_MMIO_STATUS:  mmio_val = {{(CPU6_XLEN-1){1'b0}}, err_q};
            default:           mmio_val = '0;
        endcase
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d   = state_q;
        rd_ram_d  = rd_ram_q;
        rd_mmio_d = rd_mmio_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_launch) begin
                    state_d   = ST_RESP;
                    // Misaligned loads answer 0 through the MMIO capture path.
                    rd_ram_d  = ~is_mmio & ~misal;
                    rd_mmio_d = (is_mmio & ~misal) ? mmio_val : '0;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        timer_d    = tim_wr ? writedataM : (timer_q + 32'd1);

        err_d      = err_q;
        if (new_err) begin
            err_d = 1'b1;
        end else if (sts_clr) begin
            err_d = 1'b0;
        end

        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (con_load) begin
            tx_valid_d = 1'b1;
            tx_data_d  = writedataM[7:0];
        end else if (tx_valid_q & tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rd_ram_q   <= 1'b0;
            rd_mmio_q  <= '0;
            timer_q    <= '0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_ram_q   <= rd_ram_d;
            rd_mmio_q  <= rd_mmio_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // ---------------- RAM ----------------
    // Upper address bits are not decoded, so RAM aliases across the space.
    cpu6_dmem_ram #(
        .AW (DMEM_AW)
    ) u_ram (
        .clk     (clk),
        .addr_i  (dataaddrM[DMEM_AW+1:2]),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .wdata_i (writedataM),
        .rdata_o (ram_rdata)
    );

    // ---------------- outputs ----------------
    assign readdataM   = (state_q == ST_RESP) ? (rd_ram_q ? ram_rdata : rd_mmio_q) : '0;
    assign errM        = err_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cpu6_dmem_resp.sv
`timescale 1ns/1ps
// tb_cpu6_dmem_resp
// Drives MEM-stage requests into cpu6_dmem_resp and compares every cycle
// against a behavioural model: RAM as an associative array of words, the
// timer as a plain counter, the error flag as a sticky bit and the console
// as a single-entry holding register feeding an expected-byte queue.
module tb_cpu6_dmem_resp;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] dataaddrM;
    logic [31:0] writedataM;
    logic        memwriteM;
    logic        memreadM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        errM;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        dbg_state_o;

    cpu6_dmem_resp dut (
        .clk         (clk),
        .reset       (reset),
        .dataaddrM   (dataaddrM),
        .writedataM  (writedataM),
        .memwriteM   (memwriteM),
        .memreadM    (memreadM),
        .readdataM   (readdataM),
        .stallM      (stallM),
        .errM        (errM),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- reference model state ----------------
    logic [31:0] mem_m [int];
    logic [31:0] timer_m;
    logic        err_m;
    logic        tx_full_m;
    logic [7:0]  tx_byte_m;
    logic        resp_m;
    logic [31:0] resp_val_m;
    logic        resp_known_m;
    logic [7:0]  exp_q [$];
    logic [31:0] wr_addrs [$];

    logic        last_stall;
    logic [31:0] last_rdata;
    bit          rdy_mode;
    int          checks;
    int          errors;

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        timer_m      = 32'd0;
        err_m        = 1'b0;
        tx_full_m    = 1'b0;
        tx_byte_m    = 8'd0;
        resp_m       = 1'b0;
        resp_val_m   = 32'd0;
        resp_known_m = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: inputs are already applied; check outputs at the
    // falling edge against the model, then advance the model.
    task automatic tick();
        logic        mmio, mis, bad, nerr, clr, con_acc, con_blk, tim_w, ld, hs;
        logic        exp_st, rv_known;
        logic [15:0] off;
        logic [31:0] exp_rd, rv;
        logic [7:0]  b;
        int          idx;
        if (rdy_mode) tx_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        mmio = (dataaddrM[31:16] == 16'hFFFF);
        off  = dataaddrM[15:0];
        mis  = (dataaddrM[1:0] != 2'b00);
        bad  = mmio && !(off == 16'h0 || off == 16'h4 || off == 16'h8);
        idx  = int'(dataaddrM[11:2]);
        nerr = 0; clr = 0; con_acc = 0; con_blk = 0; tim_w = 0; ld = 0;
        rv = 32'd0; rv_known = 1'b1; exp_rd = 32'd0;

        if (resp_m) begin
            exp_rd = resp_val_m;
        end else begin
            nerr = (memreadM && memwriteM) || ((memreadM || memwriteM) && (mis || bad));
            if (memwriteM && !mis && mmio) begin
                if (off == 16'h0) begin
                    if (tx_full_m && !tx_ready) con_blk = 1;
                    else con_acc = 1;
                end else if (off == 16'h4) begin
                    tim_w = 1;
                end else if (off == 16'h8) begin
                    clr = writedataM[0];
                end
            end
            if (memreadM && !memwriteM) begin
                ld = 1;
                if (mis) rv = 32'd0;
                else if (mmio) begin
                    if (off == 16'h0) rv = {31'd0, tx_full_m};
                    else if (off == 16'h4) rv = timer_m;
                    else if (off == 16'h8) rv = {31'd0, err_m};
                    else rv = 32'd0;
                end else if (mem_m.exists(idx)) rv = mem_m[idx];
                else rv_known = 1'b0;
            end
        end
        exp_st = ld || con_blk;

        check("stallM", 32'(stallM), 32'(exp_st));
        if (!resp_m || resp_known_m) check("readdataM", readdataM, exp_rd);
        check("errM", 32'(errM), 32'(err_m));
        check("tx_valid", 32'(tx_valid), 32'(tx_full_m));
        if (tx_full_m) check("tx_data", 32'(tx_data), 32'(tx_byte_m));
        check("fsm_state", 32'(dbg_state_o), 32'(resp_m));
        last_stall = exp_st;
        last_rdata = readdataM;

        hs = tx_full_m && tx_ready;
        if (hs && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check("tx_order", 32'(tx_data), 32'(b));
        end

        // advance model
        if (!resp_m && memwriteM && !mis && !mmio) mem_m[idx] = writedataM;
        timer_m = tim_w ? writedataM : timer_m + 32'd1;
        if (nerr) err_m = 1'b1;
        else if (clr) err_m = 1'b0;
        if (con_acc) begin
            tx_full_m = 1'b1;
            tx_byte_m = writedataM[7:0];
            exp_q.push_back(writedataM[7:0]);
        end else if (hs) begin
            tx_full_m = 1'b0;
        end
        resp_m       = ld;
        resp_val_m   = rv;
        resp_known_m = rv_known;

        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        memwriteM = 1'b0;
        memreadM  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        dataaddrM  = a;
        writedataM = d;
        memwriteM  = 1'b1;
        memreadM   = 1'b0;
        tick();
        for (int n = 0; n < 200 && last_stall; n++) tick();
        if (last_stall) check("store_stall_bound", 32'(stallM), 32'd0);
        memwriteM = 1'b0;
    endtask

    // Request cycle (stalled) then response cycle with the request still held.
    task automatic do_load(input logic [31:0] a);
        dataaddrM = a;
        memreadM  = 1'b1;
        memwriteM = 1'b0;
        tick();
        tick();
        memreadM = 1'b0;
    endtask

    function automatic logic [31:0] rand_ram_addr();
        logic [15:0] hi;
        hi = 16'($urandom_range(0, 16'hFFFE));
        return {hi, 4'($urandom_range(0, 15)), 10'($urandom_range(0, 31)), 2'b00};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        dataaddrM = 32'd0; writedataM = 32'd0; memwriteM = 1'b0; memreadM = 1'b0;
        tx_ready = 1'b0;
        rdy_mode = 1'b0;
        last_stall = 1'b0;
        last_rdata = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", readdataM, 32'd0);
        check("rst_stall", 32'(stallM), 32'd0);
        check("rst_err", 32'(errM), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        reset = 1'b0;

        // timer free-runs from reset release
        idle(100);
        do_load(32'hFFFF_0004);
        check("timer_100", last_rdata, 32'd100);

        // timer write and wrap
        do_store(32'hFFFF_0004, 32'hFFFF_FFFE);
        idle(3);
        do_load(32'hFFFF_0004);
        check("timer_wrap", last_rdata, 32'd1);

        // RAM store then load
        do_store(32'h0000_0040, 32'hDEAD_BEEF);
        wr_addrs.push_back(32'h0000_0040);
        do_load(32'h0000_0040);
        check("ram_rd_40", last_rdata, 32'hDEAD_BEEF);

        // console back-pressure: second byte waits for the sink
        tx_ready = 1'b0;
        do_store(32'hFFFF_0000, 32'h41);
        dataaddrM = 32'hFFFF_0000; writedataM = 32'h42; memwriteM = 1'b1;
        repeat (3) tick();
        check("con_stalled", 32'(stallM), 32'd1);
        tx_ready = 1'b1;
        tick();
        memwriteM = 1'b0;
        tick();
        tx_ready = 1'b0;

        // misaligned store, status read and clear
        do_store(32'h0000_0041, 32'h1234_5678);
        do_load(32'h0000_0040);
        check("misal_ram_kept", last_rdata, 32'hDEAD_BEEF);
        do_load(32'hFFFF_0008);
        check("status_err", last_rdata, 32'd1);
        do_store(32'hFFFF_0008, 32'd1);
        idle(1);
        check("err_cleared", 32'(errM), 32'd0);

        // read+write together: store wins, no stall, error
        dataaddrM = 32'h0000_0080; writedataM = 32'd5; memwriteM = 1'b1; memreadM = 1'b1;
        tick();
        memwriteM = 1'b0; memreadM = 1'b0;
        wr_addrs.push_back(32'h0000_0080);
        check("rw_err", 32'(errM), 32'd1);
        do_load(32'h0000_0080);
        check("rw_ram_80", last_rdata, 32'd5);

        // randomized traffic
        rdy_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int          op;
            logic [31:0] a;
            logic [15:0] o;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: begin
                    a = rand_ram_addr();
                    do_store(a, $urandom());
                    wr_addrs.push_back(a);
                end
                3, 4, 5: begin
                    a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                    a = {16'($urandom_range(0, 16'hFFFE)), 4'($urandom_range(0, 15)), a[11:0]};
                    do_load(a);
                end
                6: begin
                    o = 16'(4 * $urandom_range(0, 3));
                    do_store({16'hFFFF, o}, $urandom());
                end
                7: begin
                    o = 16'(4 * $urandom_range(0, 3));
                    do_load({16'hFFFF, o});
                end
                8: begin
                    a = rand_ram_addr() | 32'($urandom_range(1, 3));
                    if ($urandom_range(0, 1) == 1) do_load(a);
                    else do_store(a, $urandom());
                end
                default: begin
                    a = rand_ram_addr();
                    dataaddrM = a; writedataM = $urandom(); memwriteM = 1'b1; memreadM = 1'b1;
                    tick();
                    memwriteM = 1'b0; memreadM = 1'b0;
                    wr_addrs.push_back(a);
                    idle($urandom_range(0, 2));
                end
            endcase
        end

        // reset in the stall cycle of a load, with console full and error set
        rdy_mode = 1'b0;
        tx_ready = 1'b1;
        idle(2);
        tx_ready = 1'b0;
        do_store(32'hFFFF_0000, 32'h55);
        do_store(32'h0000_0043, 32'd0);
        dataaddrM = 32'h0000_0040; memreadM = 1'b1;
        #2;
        check("pre_rst_stall", 32'(stallM), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_stall", 32'(stallM), 32'd0);
        check("rst_mid_readdata", readdataM, 32'd0);
        check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_mid_err", 32'(errM), 32'd0);
        check("rst_mid_state", 32'(dbg_state_o), 32'd0);
        memreadM = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        do_load(32'h0000_0040);
        tx_ready = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
